// File: rtl/lockstep_uart_cmp.sv
// ---------------------------------------------------------------------------
// lockstep_uart_cmp
//   Output-equivalence checker for a Left/Right lockstep SoC pair. Both UART
//   TX streams are deserialised into small per-side byte FIFOs. The FIFO
//   heads are compared pairwise, and a bounded amount of skew between the
//   copies is tolerated. The LED buses are compared cycle by cycle. The first
//   divergence clears src_cand_equiv and latches a cause code. Both outputs
//   then stay frozen until XRES.
//
// Optional feature macro: DEBUG_CMP_EN
//   defined   : DEBUGLeft/DEBUGRight get their own difference timer (code 6)
//   undefined : the DEBUG inputs are ignored and code 6 never occurs
//
// Ports
//   XCLK            in   1   clock, rising edge
//   XRES            in   1   asynchronous active-high reset
//   UART_TXDLeft    in   1   Left serial TX, 8N1, idle high
//   UART_TXDRight   in   1   Right serial TX, 8N1, idle high
//   LEDLeft         in   4   Left LED bus
//   LEDRight        in   4   Right LED bus
//   DEBUGLeft       in   4   Left debug bus (DEBUG_CMP_EN only)
//   DEBUGRight      in   4   Right debug bus (DEBUG_CMP_EN only)
//   src_cand_equiv  out  1   1 while no divergence has been seen since reset
//   mismatch_code   out  3   cause of the first failure, 0 = none
//                            1 byte mismatch, 2 skew timeout, 3 FIFO overflow,
//                            4 framing error, 5 LED timeout, 6 debug timeout
//   byte_count      out  16  matched byte pairs, saturating
// ---------------------------------------------------------------------------
module lockstep_uart_cmp #(
   parameter int BAUD_DIV   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SKEW_MAX   = 64
) (
   input  logic        XCLK,
   input  logic        XRES,
   input  logic        UART_TXDLeft,
   input  logic        UART_TXDRight,
   input  logic [3:0]  LEDLeft,
   input  logic [3:0]  LEDRight,
   input  logic [3:0]  DEBUGLeft,
   input  logic [3:0]  DEBUGRight,
   output logic        src_cand_equiv,
   output logic [2:0]  mismatch_code,
   output logic [15:0] byte_count
);

   localparam int TW = $clog2(SKEW_MAX);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SKEW_MAX - 1);

   logic       push_l, push_r;
   logic       ferr_l, ferr_r;
   logic [7:0] rx_data_l, rx_data_r;
   logic [7:0] head_l, head_r;
   logic       empty_l, empty_r;
   logic       full_l, full_r;
   logic       pop;
   logic       one_pending;
   logic       led_diff;
   logic [TW-1:0] skew_timer;
   logic [TW-1:0] led_timer;
   logic       fail_mismatch, fail_skew, fail_overflow, fail_frame, fail_led;
   logic [2:0] fail_code;

   lockstep_uart_rx #(.BAUD_DIV(BAUD_DIV)) rx_left (
      .clk       (XCLK),
      .rst       (XRES),
      .rxd       (UART_TXDLeft),
      .push      (push_l),
      .data      (rx_data_l),
      .frame_err (ferr_l)
   );

   lockstep_uart_rx #(.BAUD_DIV(BAUD_DIV)) rx_right (
      .clk       (XCLK),
      .rst       (XRES),
      .rxd       (UART_TXDRight),
      .push      (push_r),
      .data      (rx_data_r),
      .frame_err (ferr_r)
   );

   lockstep_uart_fifo #(.DEPTH(FIFO_DEPTH)) fifo_left (
      .clk   (XCLK),
      .rst   (XRES),
      .push  (push_l),
      .din   (rx_data_l),
      .pop   (pop),
      .dout  (head_l),
      .empty (empty_l),
      .full  (full_l)
   );

   lockstep_uart_fifo #(.DEPTH(FIFO_DEPTH)) fifo_right (
      .clk   (XCLK),
      .rst   (XRES),
      .push  (push_r),
      .din   (rx_data_r),
      .pop   (pop),
      .dout  (head_r),
      .empty (empty_r),
      .full  (full_r)
   );

   // A pair is consumed as soon as both sides hold a byte. One side holding
   // bytes while the other holds none is the skew condition.
   assign pop         = !empty_l && !empty_r;
   assign one_pending = empty_l != empty_r;
   assign led_diff    = LEDLeft != LEDRight;

   // The timers count consecutive offending cycles and hold at SKEW_MAX-1.
   // Reaching the limit is flagged in the cycle that would be the
   // SKEW_MAX-th consecutive offending cycle.
   always_ff @(posedge XCLK or posedge XRES) begin
      if (XRES) begin
         skew_timer <= '0;
         led_timer  <= '0;
      end else begin
         if (!one_pending) begin
            skew_timer <= '0;
         end else if (skew_timer != TIMER_LAST) begin
            skew_timer <= skew_timer + TW'(1);
         end
         if (!led_diff) begin
            led_timer <= '0;
         end else if (led_timer != TIMER_LAST) begin
            led_timer <= led_timer + TW'(1);
         end
      end
   end

   assign fail_mismatch = pop && (head_l != head_r);
   assign fail_skew     = one_pending && (skew_timer == TIMER_LAST);
   // A push into a full FIFO is only legal if the same cycle pops it.
   assign fail_overflow = (push_l && full_l && !pop) || (push_r && full_r && !pop);
   assign fail_frame    = ferr_l || ferr_r;
   assign fail_led      = led_diff && (led_timer == TIMER_LAST);

`ifdef DEBUG_CMP_EN
   logic          debug_diff;
   logic          fail_debug;
   logic [TW-1:0] debug_timer;

   assign debug_diff = DEBUGLeft != DEBUGRight;
   assign fail_debug = debug_diff && (debug_timer == TIMER_LAST);

   // The debug bus gets the same tolerance as the LED bus.
   always_ff @(posedge XCLK or posedge XRES) begin
      if (XRES) begin
         debug_timer <= '0;
      end else if (!debug_diff) begin
         debug_timer <= '0;
      end else if (debug_timer != TIMER_LAST) begin
         debug_timer <= debug_timer + TW'(1);
      end
   end
`else
   logic fail_debug;
   logic unused_debug;

   assign fail_debug   = 1'b0;
   assign unused_debug = ^{DEBUGLeft, DEBUGRight};
`endif

   // Pick the highest-priority cause among everything detected this cycle.
   always_comb begin
      fail_code = 3'd0;
      if (fail_mismatch) begin
         fail_code = 3'd1;
      end else if (fail_skew) begin
         fail_code = 3'd2;
      end else if (fail_overflow) begin
         fail_code = 3'd3;
      end else if (fail_frame) begin
         fail_code = 3'd4;
      end else if (fail_led) begin
         fail_code = 3'd5;
      end else if (fail_debug) begin
         fail_code = 3'd6;
      end
   end

   // Only the first failure is recorded. After that the flag and the code
   // stay frozen, while the datapath keeps running.
   always_ff @(posedge XCLK or posedge XRES) begin
      if (XRES) begin
         src_cand_equiv <= 1'b1;
         mismatch_code  <= 3'd0;
      end else if (src_cand_equiv && (fail_code != 3'd0)) begin
         src_cand_equiv <= 1'b0;
         mismatch_code  <= fail_code;
      end
   end

   // Matched pairs are counted even after a failure has been latched.
   always_ff @(posedge XCLK or posedge XRES) begin
      if (XRES) begin
         byte_count <= 16'd0;
      end else if (pop && (head_l == head_r) && (byte_count != 16'hFFFF)) begin
         byte_count <= byte_count + 16'd1;
      end
   end

endmodule

// ---------------------------------------------------------------------------
// lockstep_uart_rx
//   8N1 receiver. Both SoC copies run on the receiver's own clock, so the
//   line is sampled directly. A start is accepted only while armed. The
//   receiver is disarmed by reset and by a framing error. It re-arms after
//   it sees the line high, so it never starts in the middle of a frame.
//   Ports: clk, rst (async, active-high), rxd serial in,
//          push (1-cycle strobe, byte valid on data),
//          data received byte, frame_err (1-cycle strobe, bad stop bit)
// ---------------------------------------------------------------------------
module lockstep_uart_rx #(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       push,
   output logic [7:0] data,
   output logic       frame_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   rx_state_t     state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shift, shift_next;
   logic          armed, armed_next;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         armed   <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
         armed   <= armed_next;
      end
   end

   // The start bit is re-checked half a bit in. From then on every sample
   // falls one full bit period later, near the centre of each bit.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      armed_next   = armed;
      push         = 1'b0;
      frame_err    = 1'b0;
      case (state)
         IDLE: begin
            if (!armed) begin
               armed_next = rxd;
            end else if (!rxd) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = '0;
               if (rxd) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_next   = '0;
               shift_next = {rxd, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rxd) begin
                  push = 1'b1;
               end else begin
                  frame_err  = 1'b1;
                  armed_next = 1'b0;
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign data = shift;

endmodule

// ---------------------------------------------------------------------------
// lockstep_uart_fifo
//   Byte FIFO with a power-of-2 depth and a show-ahead head output. A push
//   into a full FIFO is accepted only when the same cycle pops it. Otherwise
//   the byte is dropped, and the parent module reports it as an overflow.
//   The parent never pops an empty FIFO.
//   Ports: clk, rst (async, active-high), push/din write side,
//          pop read strobe, dout head byte, empty, full
// ---------------------------------------------------------------------------
module lockstep_uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          write_en;

   assign write_en = push && (!full || pop);
   assign empty    = count == '0;
   assign full     = count == FULL_COUNT;
   assign dout     = mem[rd_ptr];

   // The storage array needs no reset. Occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[wr_ptr] <= din;
      end
   end

   // The pointers wrap naturally because the depth is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (write_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({write_en, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_lockstep_uart_cmp.sv
// ---------------------------------------------------------------------------
// tb_lockstep_uart_cmp
//   Self-checking bench for lockstep_uart_cmp. Each scenario is first built
//   as per-cycle tables: serial lines, LED and debug buses, and reset. Every
//   frame the bench schedules is recorded as the byte (or framing error)
//   that must arrive once the stop bit has been sampled. A queue-based model
//   then applies the comparison rules to those arrivals, and the DUT outputs
//   are checked against the model every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lockstep_uart_cmp;

   localparam int BAUD_DIV     = 16;
   localparam int FIFO_DEPTH   = 4;
   localparam int SKEW_MAX     = 64;
   localparam int FRAME_LEN    = 10 * BAUD_DIV;
   localparam int ARRIVE_OFS   = BAUD_DIV / 2 + 9 * BAUD_DIV;
   localparam int MAXC         = 2400;
   localparam int EV_NONE      = -1;
   localparam int EV_FRAME_ERR = 256;

   logic        XCLK = 1'b0;
   logic        XRES = 1'b1;
   logic        UART_TXDLeft = 1'b1;
   logic        UART_TXDRight = 1'b1;
   logic [3:0]  LEDLeft = 4'h0;
   logic [3:0]  LEDRight = 4'h0;
   logic [3:0]  DEBUGLeft = 4'h0;
   logic [3:0]  DEBUGRight = 4'h0;
   logic        src_cand_equiv;
   logic [2:0]  mismatch_code;
   logic [15:0] byte_count;

   lockstep_uart_cmp #(
      .BAUD_DIV   (BAUD_DIV),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SKEW_MAX   (SKEW_MAX)
   ) dut (
      .XCLK           (XCLK),
      .XRES           (XRES),
      .UART_TXDLeft   (UART_TXDLeft),
      .UART_TXDRight  (UART_TXDRight),
      .LEDLeft        (LEDLeft),
      .LEDRight       (LEDRight),
      .DEBUGLeft      (DEBUGLeft),
      .DEBUGRight     (DEBUGRight),
      .src_cand_equiv (src_cand_equiv),
      .mismatch_code  (mismatch_code),
      .byte_count     (byte_count)
   );

   always #5 XCLK = ~XCLK;

   // Scoreboard counters and the scenario context used in messages.
   int    checks = 0;
   int    failures = 0;
   string scen_name = "init";
   int    cur_cycle = 0;

   // Per-cycle scenario tables.
   logic       line_l [MAXC];
   logic       line_r [MAXC];
   logic [3:0] led_l  [MAXC];
   logic [3:0] led_r  [MAXC];
   logic [3:0] dbg_l  [MAXC];
   logic [3:0] dbg_r  [MAXC];
   logic       rst_arr[MAXC];
   int         ev_l   [MAXC];
   int         ev_r   [MAXC];
   int         probe_cycle;
   logic       probe_equiv;
   logic [2:0] probe_code;

   // Reference model state.
   logic [7:0] q_l[$];
   logic [7:0] q_r[$];
   int         skew_run;
   int         led_run;
   logic       m_equiv;
   logic [2:0] m_code;
   int         m_count;

   // Count one comparison and report it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s scen=%s cycle=%0d got=%0h expected=%0h",
                  tag, scen_name, cur_cycle, got, exp);
      end
   endtask

   // Clear the tables: lines idle, buses equal, debug buses random.
   task automatic clearScenario();
      for (int k = 0; k < MAXC; k++) begin
         line_l[k]  = 1'b1;
         line_r[k]  = 1'b1;
         led_l[k]   = 4'h0;
         led_r[k]   = 4'h0;
         dbg_l[k]   = 4'($urandom);
         dbg_r[k]   = 4'($urandom);
         rst_arr[k] = 1'b0;
         ev_l[k]    = EV_NONE;
         ev_r[k]    = EV_NONE;
      end
      probe_cycle = -1;
      probe_equiv = 1'b1;
      probe_code  = 3'd0;
   endtask

   // Put an 8N1 frame on one side, with the start bit in cycles
   // start..start+BAUD_DIV-1. The byte must arrive when the stop bit is
   // sampled: half a bit for the start check, then nine full bits later.
   task automatic addFrame(input int side, input int start, input logic [7:0] data,
                           input logic stop_ok, input logic log_event);
      logic [9:0] bits;
      int         idx;
      bits = {stop_ok, data, 1'b0};
      for (int s = 0; s < 10; s++) begin
         for (int c = 0; c < BAUD_DIV; c++) begin
            idx = start + s * BAUD_DIV + c;
            if (idx < MAXC) begin
               if (side == 0) line_l[idx] = bits[s];
               else           line_r[idx] = bits[s];
            end
         end
      end
      if (log_event && (start + ARRIVE_OFS < MAXC)) begin
         if (side == 0) ev_l[start + ARRIVE_OFS] = stop_ok ? int'(data) : EV_FRAME_ERR;
         else           ev_r[start + ARRIVE_OFS] = stop_ok ? int'(data) : EV_FRAME_ERR;
      end
   endtask

   task automatic modelReset();
      q_l.delete();
      q_r.delete();
      skew_run = 0;
      led_run  = 0;
      m_equiv  = 1'b1;
      m_code   = 3'd0;
      m_count  = 0;
   endtask

   // Apply the comparison rules for one clock cycle.
   task automatic modelStep(input int k);
      logic has_l, has_r, pop, push_l, push_r, ovf_l, ovf_r;
      logic f1, f2, f3, f4, f5;
      has_l  = q_l.size() > 0;
      has_r  = q_r.size() > 0;
      pop    = has_l && has_r;
      f1     = pop && (q_l[0] != q_r[0]);
      skew_run = (has_l != has_r) ? skew_run + 1 : 0;
      f2     = skew_run >= SKEW_MAX;
      push_l = (ev_l[k] >= 0) && (ev_l[k] <= 255);
      push_r = (ev_r[k] >= 0) && (ev_r[k] <= 255);
      ovf_l  = push_l && (q_l.size() == FIFO_DEPTH) && !pop;
      ovf_r  = push_r && (q_r.size() == FIFO_DEPTH) && !pop;
      f3     = ovf_l || ovf_r;
      f4     = (ev_l[k] == EV_FRAME_ERR) || (ev_r[k] == EV_FRAME_ERR);
      led_run = (led_l[k] != led_r[k]) ? led_run + 1 : 0;
      f5     = led_run >= SKEW_MAX;
      if (pop) begin
         if ((q_l[0] == q_r[0]) && (m_count < 65535)) m_count++;
         void'(q_l.pop_front());
         void'(q_r.pop_front());
      end
      if (push_l && !ovf_l) q_l.push_back(8'(ev_l[k]));
      if (push_r && !ovf_r) q_r.push_back(8'(ev_r[k]));
      if (m_equiv) begin
         if (f1)      begin m_equiv = 1'b0; m_code = 3'd1; end
         else if (f2) begin m_equiv = 1'b0; m_code = 3'd2; end
         else if (f3) begin m_equiv = 1'b0; m_code = 3'd3; end
         else if (f4) begin m_equiv = 1'b0; m_code = 3'd4; end
         else if (f5) begin m_equiv = 1'b0; m_code = 3'd5; end
      end
   endtask

   // Hold reset for two cycles, then check the reset values.
   task automatic resetDut();
      XRES          = 1'b1;
      UART_TXDLeft  = 1'b1;
      UART_TXDRight = 1'b1;
      LEDLeft       = 4'h0;
      LEDRight      = 4'h0;
      repeat (2) @(posedge XCLK);
      @(negedge XCLK);
      cur_cycle = -1;
      checkOutput("rst_equiv", 32'(src_cand_equiv), 32'd1);
      checkOutput("rst_code",  32'(mismatch_code),  32'd0);
      checkOutput("rst_count", 32'(byte_count),     32'd0);
      modelReset();
   endtask

   // Drive the tables for len cycles. Inputs change on the falling edge,
   // and outputs are checked on the falling edge after each rising edge.
   task automatic applyStimulus(input int len);
      for (int k = 0; k < len; k++) begin
         XRES          = rst_arr[k];
         UART_TXDLeft  = line_l[k];
         UART_TXDRight = line_r[k];
         LEDLeft       = led_l[k];
         LEDRight      = led_r[k];
         DEBUGLeft     = dbg_l[k];
         DEBUGRight    = dbg_r[k];
         @(posedge XCLK);
         if (rst_arr[k]) modelReset();
         else            modelStep(k);
         @(negedge XCLK);
         cur_cycle = k;
         checkOutput("equiv", 32'(src_cand_equiv), 32'(m_equiv));
         checkOutput("code",  32'(mismatch_code),  32'(m_code));
         checkOutput("count", 32'(byte_count),     32'(m_count));
         if (k == probe_cycle) begin
            checkOutput("probe_equiv", 32'(src_cand_equiv), 32'(probe_equiv));
            checkOutput("probe_code",  32'(mismatch_code),  32'(probe_code));
         end
      end
      XRES = 1'b0;
   endtask

   task automatic runScenario(input int len);
      resetDut();
      applyStimulus(len);
   endtask

   task automatic checkEnd(input logic [31:0] exp_equiv, input logic [31:0] exp_code,
                           input logic [31:0] exp_count);
      checkOutput("end_equiv", 32'(src_cand_equiv), exp_equiv);
      checkOutput("end_code",  32'(mismatch_code),  exp_code);
      checkOutput("end_count", 32'(byte_count),     exp_count);
   endtask

   // Random traffic: mirrored streams with some skew, a corrupted byte, a
   // large skew, or independent streams. The LED buses are equal apart from
   // a few bursts of difference with random lengths.
   task automatic buildRandom(output int len);
      int n, mode, ofs, bad_idx, t, val, b, rb, bs, bl;
      logic stop_r;
      clearScenario();
      n       = $urandom_range(2, 8);
      mode    = $urandom_range(0, 3);
      ofs     = (mode == 2) ? $urandom_range(60, 120) : $urandom_range(0, 50);
      bad_idx = (mode == 1) ? $urandom_range(0, n - 1) : -1;
      t       = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) begin
         b = $urandom_range(0, 255);
         addFrame(0, t, 8'(b), 1'b1, 1'b1);
         stop_r = 1'b1;
         if (mode == 3) begin
            rb     = $urandom_range(0, 255);
            stop_r = ($urandom_range(0, 15) != 0);
         end else if (i == bad_idx) begin
            rb = b ^ (1 << $urandom_range(0, 7));
         end else begin
            rb = b;
         end
         addFrame(1, t + ofs, 8'(rb), stop_r, 1'b1);
         t += FRAME_LEN + $urandom_range(4, 44);
      end
      len = t + ofs + 120;
      val = $urandom_range(0, 15);
      for (int k = 0; k < len; k++) begin
         if ($urandom_range(0, 99) == 0) val = $urandom_range(0, 15);
         led_l[k] = 4'(val);
         led_r[k] = 4'(val);
      end
      for (int j = 0; j < 2; j++) begin
         bs = $urandom_range(0, len - 100);
         bl = $urandom_range(1, 80);
         for (int c = bs; c < bs + bl; c++) begin
            led_r[c] = led_l[c] ^ 4'($urandom_range(1, 15));
         end
      end
   endtask

   task automatic runDirected();
      // Both sides send the same byte at the same time.
      scen_name = "same_time";
      clearScenario();
      addFrame(0, 10, 8'h41, 1'b1, 1'b1);
      addFrame(1, 10, 8'h41, 1'b1, 1'b1);
      runScenario(300);
      checkEnd(32'd1, 32'd0, 32'd1);

      // Right is 40 cycles late, which is inside the skew window.
      scen_name = "skew40";
      clearScenario();
      addFrame(0, 10, 8'h41, 1'b1, 1'b1);
      addFrame(1, 50, 8'h41, 1'b1, 1'b1);
      runScenario(340);
      checkEnd(32'd1, 32'd0, 32'd1);

      // Different bytes: the flag falls on the edge after the pop.
      scen_name = "byte_diff";
      clearScenario();
      addFrame(0, 10, 8'h41, 1'b1, 1'b1);
      addFrame(1, 10, 8'h42, 1'b1, 1'b1);
      probe_cycle = 10 + ARRIVE_OFS + 1;
      probe_equiv = 1'b0;
      probe_code  = 3'd1;
      runScenario(300);
      checkEnd(32'd0, 32'd1, 32'd0);

      // Left sends five bytes while Right stays silent. The skew timeout
      // comes first, and the later overflow must not replace its code.
      scen_name = "skew_timeout";
      clearScenario();
      for (int i = 0; i < 5; i++) addFrame(0, 10 + i * (FRAME_LEN + 4), 8'(8'h30 + i), 1'b1, 1'b1);
      probe_cycle = 10 + ARRIVE_OFS + SKEW_MAX;
      probe_equiv = 1'b0;
      probe_code  = 3'd2;
      runScenario(10 + 4 * (FRAME_LEN + 4) + FRAME_LEN + 40);
      checkEnd(32'd0, 32'd2, 32'd0);

      // The LEDs differ for exactly SKEW_MAX cycles.
      scen_name = "led64";
      clearScenario();
      for (int k = 10; k < 10 + SKEW_MAX; k++) led_l[k] = 4'h1;
      probe_cycle = 10 + SKEW_MAX - 1;
      probe_equiv = 1'b0;
      probe_code  = 3'd5;
      runScenario(200);
      checkEnd(32'd0, 32'd5, 32'd0);

      // The LEDs differ for one cycle less than SKEW_MAX.
      scen_name = "led63";
      clearScenario();
      for (int k = 10; k < 10 + SKEW_MAX - 1; k++) led_l[k] = 4'h1;
      runScenario(200);
      checkEnd(32'd1, 32'd0, 32'd0);

      // A framing error on Right, then a reset pulse in the middle of a
      // frame. The pulse ends while the line is low (bit 5 of 0x0F), so the
      // receivers must not take a start from the rest of that frame.
      scen_name = "frame_err_reset";
      clearScenario();
      addFrame(1, 10, 8'h5A, 1'b0, 1'b1);
      addFrame(0, 340, 8'h0F, 1'b1, 1'b0);
      addFrame(1, 340, 8'h0F, 1'b1, 1'b0);
      for (int k = 340 + 100; k < 340 + 104; k++) rst_arr[k] = 1'b1;
      probe_cycle = 10 + ARRIVE_OFS;
      probe_equiv = 1'b0;
      probe_code  = 3'd4;
      runScenario(340 + FRAME_LEN + 60);
      checkEnd(32'd1, 32'd0, 32'd0);
   endtask

   initial begin
      int len;
      runDirected();
      for (int s = 0; s < 20; s++) begin
         scen_name = $sformatf("random%0d", s);
         buildRandom(len);
         runScenario(len);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog scen=%s cycle=%0d got=timeout expected=finish", scen_name, cur_cycle);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
